// File: rtl/cpu_lsu.sv
// rtl/cpu_lsu.sv - load/store initiator driving the data-cache port
module cpu_lsu (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_op_load,
    input  logic        i_op_store,
    input  logic [1:0]  i_op_size,
    input  logic        i_op_signed,
    input  logic [31:0] i_op_addr,
    input  logic [31:0] i_op_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_addr_err,
    output logic        o_dc_read,
    output logic        o_dc_write,
    output logic [29:0] o_dc_addr,
    output logic [31:0] o_dc_wdata,
    output logic [3:0]  o_dc_byte_w_en,
    input  logic [31:0] i_dc_data,
    input  logic        i_mem_stall
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_dc_read;
    logic        r_dc_write;
    logic [29:0] r_dc_addr;
    logic [31:0] r_dc_wdata;
    logic [3:0]  r_dc_ben;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_lane;
    logic        r_done;
    logic        r_addr_err;
    logic [31:0] r_rdata;

    logic        w_is_byte;
    logic        w_is_half;
    logic        w_one_op;
    logic        w_aligned;
    logic        w_accept;
    logic        w_misalign;
    logic        w_complete;
    logic [3:0]  w_ben;
    logic [31:0] w_wdata;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_fmt;

    // Size 3 is reserved and behaves as a word access.
    assign w_is_byte  = (i_op_size == 2'd0);
    assign w_is_half  = (i_op_size == 2'd1);
    assign w_one_op   = i_op_load ^ i_op_store;
    assign w_aligned  = w_is_byte
                      | (w_is_half & ~i_op_addr[0])
                      | (i_op_size[1] & (i_op_addr[1:0] == 2'b00));
    assign w_accept   = (r_state == S_IDLE) & w_one_op & w_aligned;
    assign w_misalign = (r_state == S_IDLE) & w_one_op & ~w_aligned;
    assign w_complete = (r_state == S_ACCESS) & ~i_mem_stall;

    // Byte-lane enables and lane-replicated write data for the incoming request
    always_comb begin
        w_ben   = 4'b0000;
        w_wdata = i_op_wdata;
        if (w_is_byte) begin
            w_ben   = 4'b0001 << i_op_addr[1:0];
            w_wdata = {4{i_op_wdata[7:0]}};
        end else if (w_is_half) begin
            w_ben   = i_op_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_op_wdata[15:0]}};
        end else begin
            w_ben   = 4'b1111;
        end
    end

    // Select the addressed lane(s) of the returned word and extend
    always_comb begin
        w_ld_byte = i_dc_data[{r_lane, 3'b000} +: 8];
        w_ld_half = r_lane[1] ? i_dc_data[31:16] : i_dc_data[15:0];
        w_ld_fmt  = i_dc_data;
        if (r_size == 2'd0) begin
            w_ld_fmt = {{24{r_signed & w_ld_byte[7]}}, w_ld_byte};
        end else if (r_size == 2'd1) begin
            w_ld_fmt = {{16{r_signed & w_ld_half[15]}}, w_ld_half};
        end
    end

    // Next-state logic: accept aligned requests, leave ACCESS on an unstalled edge
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)   w_next = S_ACCESS;
            S_ACCESS: if (w_complete) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Data-cache request registers, held stable for the whole access
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dc_read  <= 1'b0;
            r_dc_write <= 1'b0;
            r_dc_addr  <= '0;
            r_dc_wdata <= '0;
            r_dc_ben   <= 4'b0000;
            r_size     <= 2'd0;
            r_signed   <= 1'b0;
            r_lane     <= 2'd0;
        end else if (w_accept) begin
            r_dc_read  <= i_op_load;
            r_dc_write <= i_op_store;
            r_dc_addr  <= i_op_addr[31:2];
            r_dc_wdata <= w_wdata;
            r_dc_ben   <= i_op_store ? w_ben : 4'b0000;
            r_size     <= i_op_size;
            r_signed   <= i_op_signed;
            r_lane     <= i_op_addr[1:0];
        end else if (w_complete) begin
            r_dc_read  <= 1'b0;
            r_dc_write <= 1'b0;
        end
    end

    // Completion and misalignment pulses plus the load result register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_done     <= 1'b0;
            r_addr_err <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_done     <= w_complete;
            r_addr_err <= w_misalign;
            if (w_complete && r_dc_read) r_rdata <= w_ld_fmt;
        end
    end

    assign o_busy         = (r_state == S_ACCESS);
    assign o_done         = r_done;
    assign o_rdata        = r_rdata;
    assign o_addr_err     = r_addr_err;
    assign o_dc_read      = r_dc_read;
    assign o_dc_write     = r_dc_write;
    assign o_dc_addr      = r_dc_addr;
    assign o_dc_wdata     = r_dc_wdata;
    assign o_dc_byte_w_en = r_dc_ben;

endmodule

// File: doc/cpu_lsu.md
# cpu_lsu

Load/store initiator sitting between the CPU memory stage and the data-cache port of `cpu_interface`. Accepts one byte/half/word load or store per request, converts the byte address to the 30-bit word address and byte-lane enables, and drives `dc_read`/`dc_write` held stable through `mem_stall`. Returns sign- or zero-extended load data with a one-cycle `done` pulse. Misaligned accesses are trapped without touching memory.

## Interface
- none (no parameters; widths fixed by the `cpu_interface` port)

- `clk` in 1: system clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `op_load` in 1: load request, sampled while idle
- `op_store` in 1: store request, sampled while idle
- `op_size` in 2: 0 byte, 1 half, 2 word, 3 reserved (treated as word)
- `op_signed` in 1: loads only; 1 sign-extends, 0 zero-extends
- `op_addr` in 32: byte address
- `op_wdata` in 32: store data, right-aligned
- `busy` out 1: access in flight; pipeline holds its request while high
- `done` out 1: one-cycle completion pulse
- `rdata` out 32: aligned, extended load data; valid when `done`, held until the next `done`
- `addr_err` out 1: one-cycle misalignment pulse
- `dc_read` out 1: data-cache read request
- `dc_write` out 1: data-cache write request
- `dc_addr` out 30: word address, `op_addr[31:2]`
- `dc_wdata` out 32: lane-replicated store data
- `dc_byte_w_en` out 4: byte-lane write enables, bit i = byte i (little-endian)
- `dc_data` in 32: read data from the cache
- `mem_stall` in 1: responder busy; an access completes on the rising edge where the request is high and `mem_stall` is low

## Operation
- FSM states: IDLE, ACCESS.
- In IDLE, at a rising edge:
  - Exactly one of `op_load`/`op_store` high:
    - Aligned (half: `a[0]`=0; word: `a[1:0]`=0): latch the request, register the `dc_*` outputs, go to ACCESS.
    - Misaligned: assert `addr_err` for the next cycle, stay IDLE, issue no memory request.
  - Both high, or neither high: ignored; no access, no pulse.
- ACCESS:
  - `dc_read`/`dc_write`, `dc_addr`, `dc_wdata` and `dc_byte_w_en` stay constant.
  - `busy` = 1.
  - On an edge with `mem_stall` low: capture and format `dc_data` (loads), drop the request, pulse `done`, return to IDLE.
  - On an edge with `mem_stall` high: stay in ACCESS.
- Store lanes, with `a` = `op_addr[1:0]`:
  - Byte: enable = `1<<a`, `dc_wdata` = `{4{wdata[7:0]}}`.
  - Half: enable = `a[1] ? 1100 : 0011`, `dc_wdata` = `{2{wdata[15:0]}}`.
  - Word: enable = 1111, `dc_wdata` = `wdata`.
- Load reads:
  - `dc_byte_w_en` = 0000.
  - Byte: lane `a` is selected and extended per `op_signed`.
  - Half: lane pair `a[1]` is selected and extended per `op_signed`.
  - Word: passed through unchanged.
- Stores do not modify `rdata`.
- Requests presented while `busy` are not sampled.

## Timing
- Reset values (asynchronous, immediate):
  - FSM in IDLE.
  - `busy`, `done`, `addr_err`, `dc_read`, `dc_write` = 0.
  - `dc_addr`, `dc_wdata`, `rdata` = 0.
  - `dc_byte_w_en` = 0000.
- Reset during ACCESS abandons the access; the responder shares `rst`.
- Accept at edge N; `dc_*` valid and `busy` high from cycle N+1.
- With zero wait states, completion is at edge N+1 and `done` is high in cycle N+2. Each stalled cycle adds one cycle.
- Back-to-back: a new request can be accepted at the same edge that ends the `done` cycle. Minimum throughput is 2 cycles per access.
- `addr_err` is high in cycle N+1 and `busy` stays 0.
- `mem_stall` high while idle is ignored.

## Test plan
- Store then load:
  - `sw` 0x00000040 to byte address 0x80, with `mem_stall` high for 25 cycles -> `dc_write`=1, `dc_addr`=0x20, enable 1111, outputs held all 25 cycles, one `done`.
  - Then `lw` 0x80 with `dc_data`=0x40 -> `rdata`=0x00000040.
- Byte and half lanes:
  - `sb` 0xAB at 0x83 -> enable 1000, `dc_wdata`=0xABABABAB.
  - `sh` 0x1234 at 0x82 -> enable 1100, `dc_wdata`=0x12341234.
- Load extension:
  - `dc_data`=0x80FF7F01; `lb` at 0x83 signed -> 0xFFFFFF80; unsigned -> 0x00000080.
  - `lh` at 0x82 signed -> 0xFFFF80FF.
  - `lb` at 0x81 signed -> 0x0000007F.
- Misalignment:
  - `lh` at 0x81 -> `addr_err` pulse one cycle after accept, `dc_read` never asserted, `busy`=0, no `done`.
  - Same for `lw` at 0x822.
- Reset mid-stall:
  - Load to 0x820, assert `rst` while `mem_stall`=1 -> `dc_read`/`busy` drop immediately, no `done`.
  - After release, `sw` 0x820 to 0x2080 completes normally.
- Back-to-back zero-wait: stores to 0x80, 0x2080, 0x4080 with `mem_stall`=0 -> three `done` pulses 2 cycles apart, `dc_addr` 0x20, 0x820, 0x1020.
